// File: rtl/fetch_queue_unit_pkg.sv
// fetch_queue_unit_pkg
// Shared types and defaults for the fetch stage and its fetch queue.
// Contents:
//   NUM_SUPER   - fetch/dispatch width (instructions per cycle)
//   FQ_ENTRY_t  - one queued instruction: IR plus its NPC
//   F_BP_OUT_t  - per-slot bundle the fetch stage hands to the predictor
//   popcount2   - number of set bits in a 2-bit slot mask
`define NUM_SUPER 2
`define FQ_DEPTH  8
`define RESET_PC  64'h0

package fetch_queue_unit_pkg;

    localparam int NUM_SUPER = `NUM_SUPER;

    typedef struct packed {
        logic [31:0] IR;
        logic [63:0] NPC;
    } FQ_ENTRY_t;

    typedef struct packed {
        logic [NUM_SUPER-1:0][63:0] NPC;
        logic [NUM_SUPER-1:0][31:0] IR;
        logic [NUM_SUPER-1:0]       valid;
    } F_BP_OUT_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if
// Bundles the I-cache, predictor and dispatch signals of the fetch stage.
// Modports:
//   master - the fetch unit (drives Icache_addr, predictor outputs, fq_*)
//   slave  - the environment (I-cache, predictor, dispatch)
// Signals:
//   Icache_data/valid/addr      - I-cache request/response
//   if_NPC_out/if_IR_out/f_inst_valid - raw fetch pair to the predictor
//   bp_inst_valid/bp_target_pc/rollback_en - predictor responses
//   dis_num                     - instructions dispatch pops this cycle
//   fq_IR/fq_NPC/fq_valid/fq_count - queue head view and occupancy
interface fetch_queue_unit_if
    import fetch_queue_unit_pkg::*;
#(
    parameter int FQ_DEPTH = `FQ_DEPTH
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [63:0]                Icache_data;
    logic                       Icache_valid;
    logic [63:0]                Icache_addr;
    logic [NUM_SUPER-1:0][63:0] if_NPC_out;
    logic [NUM_SUPER-1:0][31:0] if_IR_out;
    logic [NUM_SUPER-1:0]       f_inst_valid;
    logic [NUM_SUPER-1:0]       bp_inst_valid;
    logic [63:0]                bp_target_pc;
    logic                       rollback_en;
    logic [1:0]                 dis_num;
    logic [NUM_SUPER-1:0][31:0] fq_IR;
    logic [NUM_SUPER-1:0][63:0] fq_NPC;
    logic [NUM_SUPER-1:0]       fq_valid;
    logic [CW-1:0]              fq_count;

    modport master (
        input  Icache_data, Icache_valid, bp_inst_valid, bp_target_pc,
               rollback_en, dis_num,
        output Icache_addr, if_NPC_out, if_IR_out, f_inst_valid,
               fq_IR, fq_NPC, fq_valid, fq_count
    );

    modport slave (
        output Icache_data, Icache_valid, bp_inst_valid, bp_target_pc,
               rollback_en, dis_num,
        input  Icache_addr, if_NPC_out, if_IR_out, f_inst_valid,
               fq_IR, fq_NPC, fq_valid, fq_count
    );

endinterface

// File: rtl/fetch_queue_unit_fq_circ_buffer.sv
// fq_circ_buffer
// Two-in / two-out circular instruction buffer with single-cycle flush.
// Ports:
//   clock, reset - clock and asynchronous active-high reset
//   flush        - empty the buffer; writes and reads that cycle are dropped
//   wr_en        - per-slot write enable; enabled slots are packed at tail
//   wr_data      - per-slot entries
//   rd_num       - entries removed from head this cycle (0..2)
//   rd_data      - entries at head and head+1
//   rd_valid     - occupancy of head and head+1
//   count        - occupancy, 0..DEPTH
module fq_circ_buffer
    import fetch_queue_unit_pkg::*;
#(
    parameter  int DEPTH = `FQ_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic [1:0]          wr_en,
    input  FQ_ENTRY_t [1:0]     wr_data,
    input  logic [1:0]          rd_num,
    output FQ_ENTRY_t [1:0]     rd_data,
    output logic [1:0]          rd_valid,
    output logic [CW-1:0]       count
);

    FQ_ENTRY_t          entries [DEPTH];
    logic [DEPTH-1:0]   entry_valid;
    logic [DEPTH-1:0]   valid_next;
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [PW-1:0]      head_plus1;
    logic [PW-1:0]      slot1_idx;
    logic [1:0]         wr_cnt;

    // Slot 1 lands right after slot 0 only when slot 0 is actually written,
    // so a lone slot-1 instruction is packed at tail without a hole.
    assign head_plus1 = head + PW'(1);
    assign slot1_idx  = tail + PW'(wr_en[0]);
    assign wr_cnt     = popcount2(wr_en);

    assign rd_data[0]  = entries[head];
    assign rd_data[1]  = entries[head_plus1];
    assign rd_valid[0] = entry_valid[head];
    assign rd_valid[1] = entry_valid[head_plus1];

    // Valid bits: clear what dispatch pops, then set what fetch pushes.
    // Writes never target a popped slot because fetch needs two free entries.
    always_comb begin
        valid_next = entry_valid;
        if (rd_num != 2'd0) valid_next[head] = 1'b0;
        if (rd_num == 2'd2) valid_next[head_plus1] = 1'b0;
        if (wr_en[0]) valid_next[tail] = 1'b1;
        if (wr_en[1]) valid_next[slot1_idx] = 1'b1;
        if (flush) valid_next = '0;
    end

    // Pointers, occupancy and valid bits; flush ignores any same-cycle pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else if (flush) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            head        <= head + PW'(rd_num);
            tail        <= tail + PW'(wr_cnt);
            count       <= count + CW'(wr_cnt) - CW'(rd_num);
            entry_valid <= valid_next;
        end
    end

    // Payload storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clock) begin
        if (!flush) begin
            if (wr_en[0]) entries[tail]      <= wr_data[0];
            if (wr_en[1]) entries[slot1_idx] <= wr_data[1];
        end
    end

    // Dispatch may never pop more than the head view shows as occupied.
    rd_num_legal: assert property (
        @(posedge clock) disable iff (reset)
        !flush |-> (rd_num <= popcount2(rd_valid))
    );

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// Fetch stage: owns the PC, issues one aligned 8-byte I-cache request per
// cycle, presents the pair to the branch predictor and queues what survives.
// Ports:
//   clock, reset - clock and asynchronous active-high reset
//   bus          - fetch_queue_unit_if.master (I-cache, predictor, dispatch)
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int          FQ_DEPTH = `FQ_DEPTH,
    parameter logic [63:0] RESET_PC = `RESET_PC
) (
    input  logic                clock,
    input  logic                reset,
    fetch_queue_unit_if.master  bus
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [63:0]        pc;
    logic [63:0]        pc_next;
    logic               fetch_ok;
    logic [CW-1:0]      count;
    F_BP_OUT_t          to_bp;
    FQ_ENTRY_t [1:0]    wr_data;
    FQ_ENTRY_t [1:0]    rd_data;
    logic [1:0]         wr_en;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^pc[1:0];

    // A fetch is accepted only if both slots are guaranteed a home, judged
    // on this cycle's occupancy so a same-cycle pop does not open room.
    assign fetch_ok = bus.Icache_valid && (count <= CW'(FQ_DEPTH - 2))
                      && !bus.rollback_en;

    // Slot 0 sits below PC when PC points at the upper word of the pair.
    always_comb begin
        to_bp.NPC[0]   = {pc[63:3], 3'b100};
        to_bp.NPC[1]   = {pc[63:3], 3'b000} + 64'd8;
        to_bp.IR[0]    = bus.Icache_data[31:0];
        to_bp.IR[1]    = bus.Icache_data[63:32];
        to_bp.valid[0] = fetch_ok && !pc[2];
        to_bp.valid[1] = fetch_ok;
    end

    assign bus.Icache_addr  = {pc[63:3], 3'b000};
    assign bus.if_NPC_out   = to_bp.NPC;
    assign bus.if_IR_out    = to_bp.IR;
    assign bus.f_inst_valid = to_bp.valid;

    // The predictor supplies the sequential address when nothing is taken,
    // so an accepted fetch and a rollback both follow bp_target_pc.
    always_comb begin
        pc_next = pc;
        if (bus.rollback_en || fetch_ok) pc_next = bus.bp_target_pc;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) pc <= RESET_PC;
        else       pc <= pc_next;
    end

    // The raw valid mask also carries the rollback and room checks, so a
    // stray predictor valid can never push into a full or flushing queue.
    always_comb begin
        wr_en = bus.bp_inst_valid & to_bp.valid;
        for (int i = 0; i < 2; i++) begin
            wr_data[i].IR  = to_bp.IR[i];
            wr_data[i].NPC = to_bp.NPC[i];
        end
    end

    fq_circ_buffer #(
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clock    (clock),
        .reset    (reset),
        .flush    (bus.rollback_en),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_num   (bus.dis_num),
        .rd_data  (rd_data),
        .rd_valid (bus.fq_valid),
        .count    (count)
    );

    assign bus.fq_IR[0]  = rd_data[0].IR;
    assign bus.fq_IR[1]  = rd_data[1].IR;
    assign bus.fq_NPC[0] = rd_data[0].NPC;
    assign bus.fq_NPC[1] = rd_data[1].NPC;
    assign bus.fq_count  = count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit
// Directed bench for fetch_queue_unit (FQ_DEPTH=8, RESET_PC=0). The bench
// plays I-cache, predictor and dispatch; expected values are hand-derived.
module tb_fetch_queue_unit;
    import fetch_queue_unit_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   passes;
    int   fails;

    fetch_queue_unit_if #(.FQ_DEPTH(8)) bus ();

    fetch_queue_unit #(
        .FQ_DEPTH (8),
        .RESET_PC (64'h0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive every environment-side input for the coming clock edge.
    task automatic apply_stimulus(input logic hit, input logic [63:0] data,
                                  input logic [1:0] bpv, input logic [63:0] target,
                                  input logic rb, input logic [1:0] dn);
        bus.Icache_valid  = hit;
        bus.Icache_data   = data;
        bus.bp_inst_valid = bpv;
        bus.bp_target_pc  = target;
        bus.rollback_en   = rb;
        bus.dis_num       = dn;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) begin
            passes++;
        end else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle and settle just past the active edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        fails  = 0;
        reset  = 1'b0;
        apply_stimulus(1'b0, 64'h0, 2'b00, 64'h0, 1'b0, 2'd0);

        // Reset state
        #1 reset = 1'b1;
        #2;
        check_output("rst_count", 64'(bus.fq_count), 64'd0);
        check_output("rst_valid", 64'(bus.fq_valid), 64'd0);
        check_output("rst_addr", bus.Icache_addr, 64'h0);
        tick();
        reset = 1'b0;

        // First hit at PC=0, sequential pair
        apply_stimulus(1'b1, 64'h1100_0004_1100_0000, 2'b11, 64'h8, 1'b0, 2'd0);
        #1;
        check_output("s1_fvalid", 64'(bus.f_inst_valid), 64'h3);
        check_output("s1_npc0", bus.if_NPC_out[0], 64'h4);
        check_output("s1_npc1", bus.if_NPC_out[1], 64'h8);
        check_output("s1_ir1", 64'(bus.if_IR_out[1]), 64'h1100_0004);
        tick();
        check_output("s1_addr", bus.Icache_addr, 64'h8);
        check_output("s1_count", 64'(bus.fq_count), 64'd2);
        check_output("s1_fqvalid", 64'(bus.fq_valid), 64'h3);
        check_output("s1_fqnpc0", bus.fq_NPC[0], 64'h4);
        check_output("s1_fqnpc1", bus.fq_NPC[1], 64'h8);
        check_output("s1_fqir0", 64'(bus.fq_IR[0]), 64'h1100_0000);
        check_output("s1_fqir1", 64'(bus.fq_IR[1]), 64'h1100_0004);

        // Miss while dispatch drains both
        apply_stimulus(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 64'h0, 1'b0, 2'd2);
        #1;
        check_output("miss_fvalid", 64'(bus.f_inst_valid), 64'h0);
        tick();
        check_output("miss_count", 64'(bus.fq_count), 64'd0);
        check_output("miss_addr", bus.Icache_addr, 64'h8);
        check_output("miss_fqvalid", 64'(bus.fq_valid), 64'h0);

        // Taken branch in slot 0 at PC=8 to 0x104
        apply_stimulus(1'b1, 64'h2200_0004_2200_0000, 2'b01, 64'h104, 1'b0, 2'd0);
        tick();
        check_output("tk1_count", 64'(bus.fq_count), 64'd1);
        check_output("tk1_addr", bus.Icache_addr, 64'h100);
        check_output("tk1_fqnpc0", bus.fq_NPC[0], 64'hC);
        check_output("tk1_fqir0", 64'(bus.fq_IR[0]), 64'h2200_0000);
        check_output("tk1_fqvalid", 64'(bus.fq_valid), 64'h1);

        // PC=0x104: slot 0 dead, slot 1 enqueued, one popped
        apply_stimulus(1'b1, 64'hCAFE_0001_DEAD_0000, 2'b10, 64'h108, 1'b0, 2'd1);
        #1;
        check_output("hi_fvalid", 64'(bus.f_inst_valid), 64'h2);
        check_output("hi_npc0", bus.if_NPC_out[0], 64'h104);
        check_output("hi_npc1", bus.if_NPC_out[1], 64'h108);
        tick();
        check_output("hi_count", 64'(bus.fq_count), 64'd1);
        check_output("hi_fqnpc0", bus.fq_NPC[0], 64'h108);
        check_output("hi_fqir0", 64'(bus.fq_IR[0]), 64'hCAFE_0001);
        check_output("hi_fqvalid", 64'(bus.fq_valid), 64'h1);
        check_output("hi_addr", bus.Icache_addr, 64'h108);

        // Taken branch in slot 0 at 0x108 to 0x400
        apply_stimulus(1'b1, 64'h3300_0004_3300_0000, 2'b01, 64'h400, 1'b0, 2'd0);
        #1;
        check_output("tk2_fvalid", 64'(bus.f_inst_valid), 64'h3);
        tick();
        check_output("tk2_count", 64'(bus.fq_count), 64'd2);
        check_output("tk2_fqnpc1", bus.fq_NPC[1], 64'h10C);
        check_output("tk2_addr", bus.Icache_addr, 64'h400);

        // Fill to 7: queue becomes 10C,404,408,40C,410,414,418
        apply_stimulus(1'b1, 64'h4400_0004_4400_0000, 2'b11, 64'h408, 1'b0, 2'd0);
        tick();
        apply_stimulus(1'b1, 64'h4400_0004_4400_0000, 2'b11, 64'h410, 1'b0, 2'd0);
        tick();
        apply_stimulus(1'b1, 64'h4400_0004_4400_0000, 2'b11, 64'h418, 1'b0, 2'd1);
        tick();
        check_output("fill_count", 64'(bus.fq_count), 64'd7);
        check_output("fill_addr", bus.Icache_addr, 64'h418);
        check_output("fill_fqnpc0", bus.fq_NPC[0], 64'h10C);

        // Near-full: hit is refused, PC holds
        apply_stimulus(1'b1, 64'h5500_0004_5500_0000, 2'b00, 64'h999, 1'b0, 2'd0);
        #1;
        check_output("full_fvalid", 64'(bus.f_inst_valid), 64'h0);
        tick();
        check_output("full_count", 64'(bus.fq_count), 64'd7);
        check_output("full_addr", bus.Icache_addr, 64'h418);

        // Pop two; fetch still refused on this cycle's count
        apply_stimulus(1'b1, 64'h5500_0004_5500_0000, 2'b00, 64'h999, 1'b0, 2'd2);
        #1;
        check_output("pop_fvalid", 64'(bus.f_inst_valid), 64'h0);
        tick();
        check_output("pop_count", 64'(bus.fq_count), 64'd5);
        check_output("pop_addr", bus.Icache_addr, 64'h418);
        check_output("pop_fqnpc0", bus.fq_NPC[0], 64'h408);

        // Fetch resumes
        apply_stimulus(1'b1, 64'h5500_0004_5500_0000, 2'b11, 64'h420, 1'b0, 2'd0);
        #1;
        check_output("res_fvalid", 64'(bus.f_inst_valid), 64'h3);
        tick();
        check_output("res_count", 64'(bus.fq_count), 64'd7);
        check_output("res_addr", bus.Icache_addr, 64'h420);

        // Drain to 2 with misses: queue becomes 41C,420
        apply_stimulus(1'b0, 64'h0, 2'b00, 64'h0, 1'b0, 2'd2);
        tick();
        tick();
        apply_stimulus(1'b0, 64'h0, 2'b00, 64'h0, 1'b0, 2'd1);
        tick();
        check_output("drain_count", 64'(bus.fq_count), 64'd2);
        check_output("drain_fqnpc0", bus.fq_NPC[0], 64'h41C);
        check_output("drain_fqnpc1", bus.fq_NPC[1], 64'h420);

        // Steady enqueue 2 / dequeue 2, pointers wrap several times
        for (int k = 0; k < 10; k++) begin
            logic [63:0] pc_k;
            pc_k = 64'h420 + 64'(8 * k);
            apply_stimulus(1'b1, 64'h6600_0004_6600_0000, 2'b11, pc_k + 64'd8, 1'b0, 2'd2);
            tick();
            check_output("wrap_count", 64'(bus.fq_count), 64'd2);
            check_output("wrap_fqnpc0", bus.fq_NPC[0], pc_k + 64'd4);
            check_output("wrap_fqnpc1", bus.fq_NPC[1], pc_k + 64'd8);
        end
        check_output("wrap_addr", bus.Icache_addr, 64'h470);

        // Fill to 6
        apply_stimulus(1'b1, 64'h7700_0004_7700_0000, 2'b11, 64'h478, 1'b0, 2'd0);
        tick();
        apply_stimulus(1'b1, 64'h7700_0004_7700_0000, 2'b11, 64'h480, 1'b0, 2'd0);
        tick();
        check_output("pre_rb_count", 64'(bus.fq_count), 64'd6);

        // Rollback with a hit and a dispatch request present
        apply_stimulus(1'b1, 64'h8800_0004_8800_0000, 2'b11, 64'h800, 1'b1, 2'd2);
        #1;
        check_output("rb_fvalid", 64'(bus.f_inst_valid), 64'h0);
        tick();
        apply_stimulus(1'b0, 64'h0, 2'b00, 64'h0, 1'b0, 2'd0);
        check_output("rb_count", 64'(bus.fq_count), 64'd0);
        check_output("rb_fqvalid", 64'(bus.fq_valid), 64'h0);
        check_output("rb_addr", bus.Icache_addr, 64'h800);

        // Refetch after rollback starts at index 0 again, then fill to 5
        apply_stimulus(1'b1, 64'h9900_0004_9900_0000, 2'b11, 64'h808, 1'b0, 2'd0);
        tick();
        check_output("post_rb_count", 64'(bus.fq_count), 64'd2);
        check_output("post_rb_fqnpc0", bus.fq_NPC[0], 64'h804);
        apply_stimulus(1'b1, 64'h9900_0004_9900_0000, 2'b11, 64'h810, 1'b0, 2'd0);
        tick();
        apply_stimulus(1'b1, 64'h9900_0004_9900_0000, 2'b11, 64'h818, 1'b0, 2'd1);
        tick();
        check_output("pre_rst_count", 64'(bus.fq_count), 64'd5);
        apply_stimulus(1'b0, 64'h0, 2'b00, 64'h0, 1'b0, 2'd0);

        // Asynchronous reset mid-cycle, well away from any clock edge
        #2 reset = 1'b1;
        #1;
        check_output("arst_count", 64'(bus.fq_count), 64'd0);
        check_output("arst_addr", bus.Icache_addr, 64'h0);
        check_output("arst_fqvalid", 64'(bus.fq_valid), 64'h0);
        tick();
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Fetch-stage block directly upstream of the branch predictor.
- Owns the PC register and issues one 8-byte-aligned I-cache request per cycle (two 32-bit Alpha instructions).
- Presents each fetched pair to the predictor (NPC, IR, valid) and redirects on the predictor's combinational target.
- Buffers surviving instructions in a circular fetch queue that dispatch drains at up to two per cycle; flushes on rollback.

Parameters:
- FQ_DEPTH, 8, fetch-queue entries; power of two, >= 4.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- Icache_data  in  64  instruction pair at Icache_addr; [31:0] = slot 0, [63:32] = slot 1
- Icache_valid  in  1  Icache_data valid this cycle (hit)
- Icache_addr  out  64  {PC[63:3], 3'b0}
- if_NPC_out  out  2x64  per-slot PC+4, sent to the predictor
- if_IR_out  out  2x32  per-slot instruction, sent to the predictor
- f_inst_valid  out  2  per-slot raw valid, sent to the predictor
- bp_inst_valid  in  2  predictor-filtered valid (post-taken, post-rollback)
- bp_target_pc  in  64  predictor next-fetch address
- rollback_en  in  1  flush request from the predictor
- dis_num  in  2  instructions dispatch removes this cycle (0..2)
- fq_IR  out  2x32  queue head and head+1 instruction
- fq_NPC  out  2x64  queue head and head+1 NPC
- fq_valid  out  2  head/head+1 occupied
- fq_count  out  $clog2(FQ_DEPTH)+1  occupancy

Behaviour:
- Reset is asynchronous, active-high. On reset: PC=RESET_PC, head=tail=0, count=0, fq_valid=0, all entry valid bits 0.
- fetch_ok = Icache_valid && (FQ_DEPTH - count >= 2) && !rollback_en.
- f_inst_valid[0] = fetch_ok && !PC[2]; f_inst_valid[1] = fetch_ok. Slot 0 is invalid when PC[2]=1.
- if_NPC_out[0] = {PC[63:3], 3'b100}; if_NPC_out[1] = {PC[63:3], 3'b000} + 8.
- if_IR_out is driven from Icache_data regardless of valid.
- Next PC, priority order:
  - rollback_en -> bp_target_pc.
  - else fetch_ok -> bp_target_pc. The predictor supplies the sequential target if_NPC_out[1] when no branch is taken.
  - else hold.
- Enqueue, same cycle, when !rollback_en: write slots with bp_inst_valid set, in slot order, at tail. Tail advances by popcount(bp_inst_valid): 0, 1 or 2.
- Dequeue: head advances by dis_num.
  - dis_num > occupied fq_valid count is illegal; assertion in sim, design behaviour undefined.
- Simultaneous enqueue and dequeue are legal: count_next = count + enq - deq, evaluated before the fetch_ok check of the next cycle only.
- fetch_ok uses the current-cycle count; no bypass of same-cycle dequeue.
- Pointers are $clog2(FQ_DEPTH) bits and wrap modulo FQ_DEPTH. fq_count distinguishes full (FQ_DEPTH) from empty (0).
- Rollback: head=tail=0, count=0 next cycle, all entries invalidated, and any dis_num that cycle is ignored. Dispatch must not consume on a rollback cycle, since the younger instructions are squashed anyway.
- fq_* outputs are combinational from queue state: a head entry is visible the cycle after enqueue (1-cycle fetch-to-dispatch latency).
- Icache miss (Icache_valid=0): no enqueue, PC holds, f_inst_valid=0.
- Full or near-full (free < 2): identical to a miss. Icache_addr remains valid so the hit repeats.

Decomposition:
- Shared package gets:
  - FQ_ENTRY_t {IR[31:0], NPC[63:0]}.
  - FQ_DEPTH and RESET_PC defaults, as `defines beside NUM_SUPER.
  - F_BP_OUT_t, reused for f_inst_valid grouping.
- One natural sub-module: fq_circ_buffer, a 2-in/2-out circular buffer with flush.
- The PC and next-PC mux stay in the top module.

Test Plan:
- Reset with RESET_PC=0, hit, bp_target_pc=8, bp_inst_valid=2'b11 -> PC becomes 8; next cycle fq_count=2, fq_NPC={8,4}, fq_valid=2'b11.
- PC=0x104 (PC[2]=1) -> f_inst_valid=2'b10, if_NPC_out[1]=0x108; bp_inst_valid=2'b10, target 0x108 -> one entry enqueued, fq_count=1.
- Taken branch in slot 0: bp_inst_valid=2'b01, bp_target_pc=0x400 -> only slot 0 enqueued; PC=0x400 next cycle.
- Fill to count=7 (FQ_DEPTH=8), then dis_num=0 with a hit -> f_inst_valid=0, PC holds; then dis_num=2 -> count=5; next cycle fetch resumes and count reaches 7.
- Wrap: 10 cycles of enq 2 / deq 2 from count=2 -> head/tail wrap past index 7, FIFO order of NPCs preserved, count stays 2.
- rollback_en=1 with target 0x800 while count=6 and a hit present -> next cycle count=0, fq_valid=0, PC=0x800, nothing from that cycle enqueued.
- Assert reset mid-operation with count=5 -> immediately count=0, PC=RESET_PC, without waiting for a clock edge.
